// File: rtl/aes_seq_ctrl.sv
// aes_seq_ctrl: register-driven launch/wait/capture sequencer between the OCL register decode and the AES core.
// Optional busy-state abort is enabled by defining AES_SEQ_TIMEOUT_EN.
module aes_seq_ctrl #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_wr_addr,
    input  logic [31:0]       reg_wr_data,
    input  logic              reg_rd_en,
    input  logic [ADDR_W-1:0] reg_rd_addr,
    output logic              reg_rd_valid,
    output logic [31:0]       reg_rd_data,
    output logic              aes_start,
    output logic [127:0]      aes_key,
    output logic [127:0]      aes_pt,
    input  logic              aes_done,
    input  logic [127:0]      aes_ct,
    output logic              busy,
    output logic              irq_done
);

`ifdef AES_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int unsigned IDX_W = 6;
    localparam logic [IDX_W-1:0] IDX_CTRL   = 6'h00;
    localparam logic [IDX_W-1:0] IDX_STATUS = 6'h01;
    localparam logic [IDX_W-1:0] IDX_LAT    = 6'h10;
    localparam logic [3:0]       GRP_KEY    = 4'h1;
    localparam logic [3:0]       GRP_PT     = 4'h2;
    localparam logic [3:0]       GRP_CT     = 4'h3;
    localparam logic [31:0]      RD_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_BUSY    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [3:0][31:0]  key_q;
    logic [3:0][31:0]  pt_q;
    logic [3:0][31:0]  ct_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  lat_q;
    logic              done_q;
    logic              err_q;
    logic              timeout_q;

    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              in_busy_c;
    logic              wr_key_c;
    logic              wr_pt_c;
    logic              wr_start_c;
    logic              wr_clear_c;
    logic              err_set_c;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              cnt_hit_c;
    logic              launch_c;
    logic              capture_c;
    logic              abort_c;
    logic [31:0]       rd_mux_c;

    // Only address bits [7:2] select a register; the rest are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{reg_wr_addr[ADDR_W-1:8], reg_wr_addr[1:0],
                                reg_rd_addr[ADDR_W-1:8], reg_rd_addr[1:0]};

    assign wr_idx = reg_wr_addr[7:2];
    assign rd_idx = reg_rd_addr[7:2];

    assign aes_key = key_q;
    assign aes_pt  = pt_q;

    // Write decode; busy-time writes to key/pt/start are dropped and flagged.
    assign in_busy_c  = (state == S_LAUNCH) || (state == S_BUSY);
    assign wr_key_c   = reg_wr_en && (wr_idx[5:2] == GRP_KEY);
    assign wr_pt_c    = reg_wr_en && (wr_idx[5:2] == GRP_PT);
    assign wr_start_c = reg_wr_en && (wr_idx == IDX_CTRL) && reg_wr_data[0];
    assign wr_clear_c = reg_wr_en && (wr_idx == IDX_CTRL) && reg_wr_data[1];
    assign err_set_c  = in_busy_c && (wr_key_c || wr_pt_c || wr_start_c);

    // Latency counter value including the current busy cycle, saturating.
    assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign cnt_hit_c = TIMEOUT_EN && (32'(cnt_inc_c) >= TIMEOUT_CYCLES);

    always_comb begin
        state_next = state;
        launch_c   = 1'b0;
        capture_c  = 1'b0;
        abort_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (wr_start_c) begin
                    state_next = S_LAUNCH;
                    launch_c   = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_next = S_BUSY;
            end
            S_BUSY: begin
                // A done on the timeout cycle still counts as a completion.
                if (aes_done) begin
                    state_next = S_CAPTURE;
                    capture_c  = 1'b1;
                end else if (cnt_hit_c) begin
                    state_next = S_IDLE;
                    abort_c    = 1'b1;
                end
            end
            S_CAPTURE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sequencer outputs, counter and status flags.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            aes_start <= 1'b0;
            busy      <= 1'b0;
            irq_done  <= 1'b0;
            cnt_q     <= '0;
            lat_q     <= '0;
            ct_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            aes_start <= launch_c;
            busy      <= (state_next == S_LAUNCH) || (state_next == S_BUSY);
            irq_done  <= capture_c || abort_c;

            if (state == S_LAUNCH) begin
                cnt_q <= '0;
            end else if (state == S_BUSY) begin
                cnt_q <= cnt_inc_c;
            end

            if (capture_c) begin
                ct_q  <= aes_ct;
                lat_q <= cnt_inc_c;
            end

            if (capture_c) begin
                done_q <= 1'b1;
            end else if (wr_clear_c || launch_c) begin
                done_q <= 1'b0;
            end

            if (err_set_c) begin
                err_q <= 1'b1;
            end else if (wr_clear_c) begin
                err_q <= 1'b0;
            end

            if (abort_c) begin
                timeout_q <= 1'b1;
            end else if (wr_clear_c) begin
                timeout_q <= 1'b0;
            end
        end
    end

    // Key and plaintext registers are frozen while the core is running.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            key_q <= '0;
            pt_q  <= '0;
        end else if (!in_busy_c) begin
            if (wr_key_c) begin
                key_q[wr_idx[1:0]] <= reg_wr_data;
            end
            if (wr_pt_c) begin
                pt_q[wr_idx[1:0]] <= reg_wr_data;
            end
        end
    end

    always_comb begin
        rd_mux_c = RD_DEFAULT;
        if (rd_idx == IDX_CTRL) begin
            rd_mux_c = 32'h0;
        end else if (rd_idx == IDX_STATUS) begin
            rd_mux_c = {28'h0, timeout_q, err_q, done_q, busy};
        end else if (rd_idx[5:2] == GRP_KEY) begin
            rd_mux_c = key_q[rd_idx[1:0]];
        end else if (rd_idx[5:2] == GRP_PT) begin
            rd_mux_c = pt_q[rd_idx[1:0]];
        end else if (rd_idx[5:2] == GRP_CT) begin
            rd_mux_c = ct_q[rd_idx[1:0]];
        end else if (rd_idx == IDX_LAT) begin
            rd_mux_c = 32'(lat_q);
        end
    end

    // Read data is sampled from pre-write register state and held until the next read.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            reg_rd_valid <= 1'b0;
            reg_rd_data  <= '0;
        end else begin
            reg_rd_valid <= reg_rd_en;
            if (reg_rd_en) begin
                reg_rd_data <= rd_mux_c;
            end
        end
    end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Scoreboard bench for aes_seq_ctrl: read expectations are queued at issue and checked when read data returns.
module tb_aes_seq_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TO_CYC = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              reg_wr_en = 1'b0;
    logic [ADDR_W-1:0] reg_wr_addr = '0;
    logic [31:0]       reg_wr_data = '0;
    logic              reg_rd_en = 1'b0;
    logic [ADDR_W-1:0] reg_rd_addr = '0;
    logic              reg_rd_valid;
    logic [31:0]       reg_rd_data;
    logic              aes_start;
    logic [127:0]      aes_key;
    logic [127:0]      aes_pt;
    logic              aes_done = 1'b0;
    logic [127:0]      aes_ct = '0;
    logic              busy;
    logic              irq_done;

    int                n_cmp = 0;
    int                n_bad = 0;
    int                irq_cnt = 0;
    int                starts = 0;
    int                model_delay = 0;
    logic [127:0]      model_ct = '0;
    logic              rd_pend = 1'b0;
    logic [31:0]       exp_data[$];
    string             exp_tag[$];

    always #5 clk = ~clk;

    aes_seq_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO_CYC), .CNT_W(16)) dut (
        .clk_main_a0 (clk),
        .rst_main_n  (rst_n),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_valid(reg_rd_valid),
        .reg_rd_data (reg_rd_data),
        .aes_start   (aes_start),
        .aes_key     (aes_key),
        .aes_pt      (aes_pt),
        .aes_done    (aes_done),
        .aes_ct      (aes_ct),
        .busy        (busy),
        .irq_done    (irq_done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Core model: counts start pulses and returns aes_done model_delay cycles after the start cycle.
    initial begin
        int   cd;
        logic start_seen;
        cd = 0;
        forever begin
            @(posedge clk);
            start_seen = aes_start;
            #1;
            aes_done = 1'b0;
            if (start_seen) begin
                starts++;
                cd = model_delay;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    aes_done = 1'b1;
                    aes_ct   = model_ct;
                end
            end
        end
    end

    always @(posedge clk) rd_pend <= reg_rd_en;

    always @(negedge clk) begin
        if (irq_done) irq_cnt++;
        if (reg_rd_valid || rd_pend) check("rd_valid_timing", 128'(reg_rd_valid), 128'(rd_pend));
        if (reg_rd_valid) begin
            check("rd_q_nonempty", 128'(exp_data.size() > 0), 128'(1));
            if (exp_data.size() > 0) begin
                logic [31:0] d;
                string       t;
                d = exp_data.pop_front();
                t = exp_tag.pop_front();
                check(t, 128'(reg_rd_data), 128'(d));
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_wr_en   = 1'b1;
        reg_wr_addr = ADDR_W'(a);
        reg_wr_data = d;
        @(posedge clk); #1;
        reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
        reg_rd_en   = 1'b1;
        reg_rd_addr = ADDR_W'(a);
        exp_data.push_back(e);
        exp_tag.push_back(tag);
        @(posedge clk); #1;
        reg_rd_en = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_drop_in_budget", 128'(busy), 128'(0));
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input logic [31:0] ctrl, input int dly, input logic [127:0] ct, output int n);
        model_delay = dly;
        model_ct    = ct;
        wr(8'h00, ctrl);
        wait_idle(n);
    endtask

    logic [127:0] ct1 = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
    logic [127:0] ct2 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
    logic [127:0] ct3 = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
    logic [127:0] ct4 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    logic [127:0] ct5 = 128'hA5A5A5A5_5A5A5A5A_3C3C3C3C_C3C3C3C3;
    logic [127:0] last_ct;

    initial begin
        int n;
        int exp_starts;
        int exp_irq;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_start", 128'(aes_start), 128'(0));
        check("rst_irq", 128'(irq_done), 128'(0));
        check("rst_rd_valid", 128'(reg_rd_valid), 128'(0));
        check("rst_rd_data", 128'(reg_rd_data), 128'(0));
        check("rst_key", aes_key, 128'(0));
        check("rst_pt", aes_pt, 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic encryption
        wr(8'h10, 32'h0F0E0D0C); wr(8'h14, 32'h0B0A0908);
        wr(8'h18, 32'h07060504); wr(8'h1C, 32'h03020100);
        wr(8'h20, 32'h33221100); wr(8'h24, 32'h77665544);
        wr(8'h28, 32'hBBAA9988); wr(8'h2C, 32'hFFEEDDCC);
        model_delay = 10;
        model_ct    = ct1;
        wr(8'h00, 32'h1);
        check("start_pulse", 128'(aes_start), 128'(1));
        check("busy_in_launch", 128'(busy), 128'(1));
        check("key_word0", 128'(aes_key[31:0]), 128'(32'h0F0E0D0C));
        check("pt_word3", 128'(aes_pt[127:96]), 128'(32'hFFEEDDCC));
        wait_idle(n);
        exp_starts = 1;
        exp_irq    = 1;
        check("busy_cycles_t1", 128'(n), 128'(11));
        check("starts_t1", 128'(starts), 128'(exp_starts));
        check("irq_t1", 128'(irq_cnt), 128'(exp_irq));
        rd(8'h30, ct1[31:0], "ct0_t1");   rd(8'h34, ct1[63:32], "ct1_t1");
        rd(8'h38, ct1[95:64], "ct2_t1");  rd(8'h3C, ct1[127:96], "ct3_t1");
        rd(8'h04, 32'h2, "status_t1");    rd(8'h40, 32'd10, "lat_t1");
        rd(8'h00, 32'h0, "ctrl_reads_0");

        // Clear+start with done set; CT read while busy returns old ciphertext
        model_delay = 6;
        model_ct    = ct3;
        wr(8'h00, 32'h3);
        rd(8'h04, 32'h1, "status_busy_cleared");
        rd(8'h30, ct1[31:0], "ct0_old_during_busy");
        wait_idle(n);
        exp_starts++; exp_irq++;
        rd(8'h04, 32'h2, "status_t6");
        rd(8'h40, 32'd6, "lat_t6");
        rd(8'h3C, ct3[127:96], "ct3_t6");

        // Writes while busy are dropped and flagged
        model_delay = 20;
        model_ct    = ct2;
        wr(8'h00, 32'h1);
        repeat (3) begin @(posedge clk); #1; end
        wr(8'h10, 32'h11111111);
        wr(8'h00, 32'h1);
        wr(8'h24, 32'h22222222);
        wait_idle(n);
        exp_starts++; exp_irq++;
        check("starts_t2", 128'(starts), 128'(exp_starts));
        check("irq_t2", 128'(irq_cnt), 128'(exp_irq));
        rd(8'h10, 32'h0F0E0D0C, "key0_unchanged");
        rd(8'h24, 32'h77665544, "pt1_unchanged");
        rd(8'h04, 32'h6, "status_err");
        wr(8'h00, 32'h2);
        rd(8'h04, 32'h0, "status_cleared");
        last_ct = ct2;

        // Unmapped read and back-to-back reads
        rd(8'h44, 32'hDEADBEEF, "unmapped_44");
        rd(8'h30, ct2[31:0], "b2b_ct0");
        rd(8'h04, 32'h0, "b2b_status");

        // Same-cycle write and read of KEY1 returns the old value
        reg_wr_en = 1'b1; reg_wr_addr = ADDR_W'(8'h14); reg_wr_data = 32'hA5A5A5A5;
        rd(8'h14, 32'h0B0A0908, "rw_old_key1");
        reg_wr_en = 1'b0;
        rd(8'h14, 32'hA5A5A5A5, "rw_new_key1");

`ifdef AES_SEQ_TIMEOUT_EN
        run(32'h1, 0, ct4, n);
        exp_starts++; exp_irq++;
        check("busy_cycles_timeout", 128'(n), 128'(TO_CYC + 1));
        check("irq_timeout", 128'(irq_cnt), 128'(exp_irq));
        rd(8'h04, 32'h8, "status_timeout");
        rd(8'h30, last_ct[31:0], "ct0_unchanged_timeout");
        rd(8'h40, 32'd20, "lat_unchanged_timeout");
        run(32'h3, TO_CYC, ct4, n);
        exp_starts++; exp_irq++;
        check("busy_cycles_done_at_limit", 128'(n), 128'(TO_CYC + 1));
        rd(8'h04, 32'h2, "status_done_wins");
        rd(8'h40, TO_CYC, "lat_done_at_limit");
        rd(8'h3C, ct4[127:96], "ct3_done_at_limit");
`else
        run(32'h3, 40, ct4, n);
        exp_starts++; exp_irq++;
        check("busy_cycles_long", 128'(n), 128'(41));
        rd(8'h04, 32'h2, "status_long");
        rd(8'h40, 32'd40, "lat_long");
        rd(8'h3C, ct4[127:96], "ct3_long");
`endif
        check("starts_pre_reset", 128'(starts), 128'(exp_starts));
        check("irq_pre_reset", 128'(irq_cnt), 128'(exp_irq));

        // Asynchronous reset during BUSY
        model_delay = 5;
        model_ct    = ct3;
        wr(8'h00, 32'h1);
        exp_starts++;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 128'(busy), 128'(0));
        check("rst_mid_key", aes_key, 128'(0));
        check("rst_mid_start", 128'(aes_start), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        check("starts_after_reset", 128'(starts), 128'(exp_starts));
        check("irq_late_done_ignored", 128'(irq_cnt), 128'(exp_irq));
        rd(8'h04, 32'h0, "status_after_reset");
        rd(8'h30, 32'h0, "ct0_after_reset");
        rd(8'h40, 32'h0, "lat_after_reset");
        rd(8'h10, 32'h0, "key0_after_reset");
        run(32'h1, 3, ct5, n);
        exp_starts++; exp_irq++;
        check("starts_post_reset_run", 128'(starts), 128'(exp_starts));
        check("irq_post_reset_run", 128'(irq_cnt), 128'(exp_irq));
        rd(8'h04, 32'h2, "status_post_reset_run");
        rd(8'h40, 32'd3, "lat_post_reset_run");
        rd(8'h34, ct5[63:32], "ct1_post_reset_run");

        repeat (4) begin @(posedge clk); #1; end
        check("rd_q_drained", 128'(exp_data.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
